// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: recovers digits from a multiplexed active-low seven-segment bus
// Ports: clk/rst (async active-high); sample_en qualifies seg_in (g..a) and dig_sel;
// out_valid/out_ready/out_digit/out_index/out_err form the one-deep event port;
// digits/digits_vld hold the per-position bank; overflow is sticky on a dropped event.
// Define SEGDEC_HEX_EN to also accept the hex letter patterns A..F.
module sevenseg_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_en,
    input  logic [6:0]                seg_in,
    input  logic [$clog2(NDIG)-1:0]   dig_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3:0]                out_digit,
    output logic [$clog2(NDIG)-1:0]   out_index,
    output logic                      out_err,
    output logic [4*NDIG-1:0]         digits,
    output logic [NDIG-1:0]           digits_vld,
    output logic                      overflow
);
    localparam int IW = $clog2(NDIG);
    localparam logic [3:0] STB = 4'(STABLE);
    typedef enum logic {TRACK, LOCKED} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [IW+6:0] last, last_n;
    logic eval, same, in_range, new_ev, load;
    logic [4:0] dec;
    // Returns {err, value}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
`ifdef SEGDEC_HEX_EN
            7'b0001000: decode = 5'h0A;
            7'b0000011: decode = 5'h0B;
            7'b1000110: decode = 5'h0C;
            7'b0100001: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001110: decode = 5'h0F;
`endif
            default:    decode = 5'h1F;
        endcase
    endfunction
    assign dec      = decode(seg_in);
    assign in_range = int'(dig_sel) < NDIG;
    assign same     = {dig_sel, seg_in} == last;
    // A locked tracker ignores repeats; any other in-range sample advances or restarts the run
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        eval    = 1'b0;
        if (sample_en && !in_range) begin
            state_n = TRACK;
            cnt_n   = '0;
        end else if (sample_en && (!same || state == TRACK)) begin
            last_n  = {dig_sel, seg_in};
            cnt_n   = !same ? 4'd1 : (cnt == STB ? STB : cnt + 4'd1);
            eval    = cnt_n == STB;
            state_n = eval ? LOCKED : TRACK;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TRACK;
            cnt   <= '0;
            last  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end
    assign new_ev = eval && (!digits_vld[dig_sel] || digits[{dig_sel, 2'b00} +: 4] != dec[3:0]);
    assign load   = new_ev && (!out_valid || out_ready);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_digit  <= '0;
            out_index  <= '0;
            out_err    <= 1'b0;
            digits     <= '1;
            digits_vld <= '0;
            overflow   <= 1'b0;
        end else begin
            if (new_ev) begin
                digits[{dig_sel, 2'b00} +: 4] <= dec[3:0];
                digits_vld[dig_sel]           <= 1'b1;
            end
            if (load) begin
                out_digit <= dec[3:0];
                out_index <= dig_sel;
                out_err   <= dec[4];
            end
            if (new_ev && !load)
                overflow <= 1'b1;
            out_valid <= load || (out_valid && !out_ready);
        end
    end
endmodule

// File: tb/tb_sevenseg_decoder.sv
// tb_sevenseg_decoder: directed vectors with an event scoreboard for sevenseg_decoder
module tb_sevenseg_decoder;
    logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, out_ready = 1'b1;
    logic [6:0] seg_in = '0;
    logic [1:0] dig_sel = '0;
    logic out_valid, out_err, overflow;
    logic [3:0] out_digit, digits_vld;
    logic [1:0] out_index;
    logic [15:0] digits;
    logic [6:0] exp_q[$];
    logic [6:0] e;
    int ncmp = 0, nbad = 0;
    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
    localparam logic [6:0] P5 = 7'b0010010, P7 = 7'b1111000, BL = 7'b1111111, PA = 7'b0001000;
    sevenseg_decoder #(.NDIG(4), .STABLE(3)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in), .dig_sel(dig_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_index(out_index), .out_err(out_err), .digits(digits),
        .digits_vld(digits_vld), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask
    task automatic samp(input logic [1:0] i, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            sample_en = 1'b1;
            dig_sel   = i;
            seg_in    = s;
            @(posedge clk);
            #1;
        end
        sample_en = 1'b0;
    endtask
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk_reset(input string name);
        chk({name, "_valid"}, 32'(out_valid), 0);
        chk({name, "_payload"}, {25'd0, out_err, out_digit, out_index}, 0);
        chk({name, "_digits"}, 32'(digits), 32'hFFFF);
        chk({name, "_vld"}, 32'(digits_vld), 0);
        chk({name, "_ovf"}, 32'(overflow), 0);
    endtask
    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 chk_reset("async_rst");
        rst = 1'b0;
    endtask
    // Monitor: every handshake must match the oldest expected event {err, digit, index}
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nbad++;
                $display("FAIL event_unexpected: actual {%0h,%0d,%0d} required none", out_digit, out_index, out_err);
            end else begin
                e = exp_q.pop_front();
                chk("event", {25'd0, out_err, out_digit, out_index}, {25'd0, e});
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end
    initial begin
        cycles(2);
        chk_reset("reset");
        rst = 1'b0;
        cycles(1);
        samp(2, P2, 2);
        chk("latency_2", 32'(out_valid), 0);
        exp_q.push_back({1'b0, 4'd2, 2'd2});
        samp(2, P2, 1);
        chk("latency_3", 32'(out_valid), 1);
        chk("digit2", 32'(digits[11:8]), 2);
        chk("vld_0100", 32'(digits_vld), 32'b0100);
        samp(2, P2, 20);
        exp_q.push_back({1'b0, 4'd1, 2'd3});
        samp(3, P1, 3);
        samp(2, P2, 3);
        cycles(3);
        chk("bank_12FF", 32'(digits), 32'h12FF);
        exp_q.push_back({1'b0, 4'd3, 2'd1});
        samp(1, P3, 2);
        samp(1, BL, 1);
        samp(1, P3, 3);
        cycles(3);
        chk("vld_1110", 32'(digits_vld), 32'b1110);
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 4'd5, 2'd0});
        samp(0, P5, 3);
        samp(1, P7, 3);
        chk("overflow", 32'(overflow), 1);
        chk("bank_drop", 32'(digits[7:4]), 7);
        cycles(3);
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_payload", {25'd0, out_err, out_digit, out_index}, {25'd0, 1'b0, 4'd5, 2'd0});
        out_ready = 1'b1;
        cycles(3);
        chk("drained_valid", 32'(out_valid), 0);
`ifdef SEGDEC_HEX_EN
        exp_q.push_back({1'b0, 4'hA, 2'd3});
`else
        exp_q.push_back({1'b1, 4'hF, 2'd3});
`endif
        samp(3, PA, 3);
        cycles(3);
        samp(0, P0, 2);
        pulse_rst();
        samp(0, P0, 1);
        chk("cnt_cleared", 32'(out_valid), 0);
        cycles(1);
        out_ready = 1'b0;
        samp(2, P2, 3);
        chk("pending", 32'(out_valid), 1);
        pulse_rst();
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 4'd0, 2'd0});
        samp(0, P0, 3);
        chk("fresh_valid", 32'(out_valid), 1);
        cycles(3);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
